cpu_step_ctrl: RTL
==================

// Module: cpu_step_ctrl
// PURPOSE
//  Consumes the slow clk1HZ square wave from the clock divider and produces a
//  one-CLOCK_50-cycle enable pulse, cpu_en, for the pipelined processor.
//  Supports free-run, single-step via a debounced pushbutton, and latched halt.
//  The processor stays on CLOCK_50 and advances only when cpu_en is high,
//  so no logic is clocked from a derived clock.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable samples before key level changes (10 ms at 50 MHz)
//  CNT_W            16      width of step_count
// PORTS
//  CLOCK_50    in   1      system clock, 50 MHz
//  reset       in   1      asynchronous, active-low reset
//  clk1HZ      in   1      slow square wave from the clock divider; asynchronous to this logic
//  key_step    in   1      single-step pushbutton, active-low, raw/bouncy
//  sw_run      in   1      run switch, 1 = free-run; raw
//  halt        in   1      processor halt request, synchronous to CLOCK_50
//  cpu_en      out  1      processor advance enable, one-cycle pulse
//  state       out  2      00 PAUSE, 01 RUN, 10 STEP, 11 HALTED
//  step_count  out  CNT_W  number of cpu_en pulses issued
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): cpu_en=0, state=PAUSE, step_count=0.
//    All synchronizer flops are cleared. Debounced key is set to released (1)
//    and the debounce counter is cleared.
//  - clk1HZ synchronization: registered through s1 -> s2 -> s3.
//    tick = s2 & ~s3, one cycle per clk1HZ rising edge.
//  - sw_run and key_step each pass through a 2-FF synchronizer.
//  - Debounce:
//    - The counter resets whenever the synced key equals the debounced level.
//    - Otherwise it increments.
//    - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips
//      and the counter clears.
//    - press = debounced 1->0 transition, one cycle wide.
//  - cpu_en is registered: cpu_en <= tick & (state==RUN | state==STEP).
//    - It rises on the 3rd CLOCK_50 edge after clk1HZ is first sampled high.
//    - Pulse width is exactly 1 cycle.
//  - FSM, evaluated every CLOCK_50 edge:
//    - PAUSE: sw_run=1 -> RUN. Else press -> STEP. Both true -> RUN.
//    - RUN: sw_run=0 -> PAUSE. A tick in the same cycle still issues cpu_en.
//      press is ignored.
//    - STEP: wait for tick; on tick issue cpu_en and go to PAUSE.
//      sw_run and press are ignored while in STEP; presses are not queued.
//    - HALTED: cpu_en=0; exit only by reset.
//  - step_count increments by 1 on every cycle cpu_en=1.
//    It wraps from 2^CNT_W-1 to 0 with no flag.
//  - Reset asserted mid-pulse forces cpu_en low immediately; a partial step is lost.
// CONFIGURATION
//  HALT_EN defined:
//    - halt=1 in any state -> HALTED on the next edge.
//    - halt has priority over tick, sw_run and press.
//    - The transition cycle issues no cpu_en.
//  HALT_EN undefined:
//    - halt is ignored and HALTED (11) is unreachable.
//    - The FSM uses only PAUSE, RUN and STEP.
// TESTING (sim with DEBOUNCE_CYCLES=4)
//  1. sw_run=1, clk1HZ period 20 cycles -> cpu_en 1-cycle pulse 3 edges after each rise;
//     step_count 1, 2, 3 after three rises.
//  2. sw_run=0, key_step low 12 cycles -> state=10.
//     Next clk1HZ rise -> one pulse, state=00. Following rise -> no pulse.
//  3. key_step toggles every 2 cycles for 16 cycles, then held low -> exactly one
//     PAUSE->STEP entry and one cpu_en on the next tick.
//  4. HALT_EN defined, RUN, halt=1 for 1 cycle coincident with tick -> cpu_en stays 0,
//     state=11, no pulses on 3 further rises.
//     HALT_EN undefined, same stimulus -> state=01 and the pulse is issued.
//  5. RUN with cpu_en=1, reset driven low between clock edges -> cpu_en=0, state=00,
//     step_count=0 with no clock edge. After release, sw_run=1 -> pulses resume.
//  6. CNT_W=4, run 17 ticks -> step_count goes 15 -> 0 -> 1; cpu_en unaffected.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns the slow clk1HZ square wave into one-cycle cpu_en pulses with
// free-run, debounced single-step and, when HALT_EN is defined, a latched halt state.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 16
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             clk1HZ,
  input  logic             key_step,
  input  logic             sw_run,
  input  logic             halt,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_count
);

  localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    PAUSE  = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  logic hz_s1_q, hz_s2_q, hz_s3_q;
  logic run_s1_q, run_s2_q;
  logic key_s1_q, key_s2_q;
  logic key_deb_q, key_deb_d;
  logic key_deb_prev_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic tick, press, halt_req;

  state_t          state_q;
  logic            cpu_en_q;
  logic [CNT_W-1:0] step_count_q;

`ifdef HALT_EN
  assign halt_req = halt;
`else
  logic unused_halt;
  assign unused_halt = halt;
  assign halt_req    = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      hz_s1_q  <= 1'b0;
      hz_s2_q  <= 1'b0;
      hz_s3_q  <= 1'b0;
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
      key_s1_q <= 1'b0;
      key_s2_q <= 1'b0;
    end else begin
      hz_s1_q  <= clk1HZ;
      hz_s2_q  <= hz_s1_q;
      hz_s3_q  <= hz_s2_q;
      run_s1_q <= sw_run;
      run_s2_q <= run_s1_q;
      key_s1_q <= key_step;
      key_s2_q <= key_s1_q;
    end
  end

  assign tick = hz_s2_q & ~hz_s3_q;

  // The level only flips after DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_comb begin
    db_cnt_d  = db_cnt_q;
    key_deb_d = key_deb_q;
    if (key_s2_q == key_deb_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d  = '0;
      key_deb_d = ~key_deb_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      db_cnt_q       <= '0;
      key_deb_q      <= 1'b1;
      key_deb_prev_q <= 1'b1;
    end else begin
      db_cnt_q       <= db_cnt_d;
      key_deb_q      <= key_deb_d;
      key_deb_prev_q <= key_deb_q;
    end
  end

  assign press = key_deb_prev_q & ~key_deb_q;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q      <= PAUSE;
      cpu_en_q     <= 1'b0;
      step_count_q <= '0;
    end else begin
      if (cpu_en_q) begin
        step_count_q <= step_count_q + CNT_W'(1);
      end
      cpu_en_q <= 1'b0;
      if (halt_req) begin
        state_q <= HALTED;
      end else begin
        case (state_q)
          PAUSE: begin
            if (run_s2_q) begin
              state_q <= RUN;
            end else if (press) begin
              state_q <= STEP;
            end
          end
          RUN: begin
            cpu_en_q <= tick;
            if (!run_s2_q) begin
              state_q <= PAUSE;
            end
          end
          // Presses and the run switch are deliberately ignored until the step fires.
          STEP: begin
            cpu_en_q <= tick;
            if (tick) begin
              state_q <= PAUSE;
            end
          end
          HALTED: begin
            state_q <= HALTED;
          end
          default: begin
            state_q <= PAUSE;
          end
        endcase
      end
    end
  end

  assign cpu_en     = cpu_en_q;
  assign state      = state_q;
  assign step_count = step_count_q;

endmodule
